load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 55 +++++
 rtl/lsu_lane_align.sv | 58 +++++
 rtl/load_store_unit.sv | 148 ++++++++++++++
 tb/tb_load_store_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and big-endian lane constants for the load/store unit
//
// Purpose: access-size encoding, FSM state encoding, big-endian lane offsets
// and small helpers shared by load_store_unit and lsu_lane_align.
// Ports: none (package).

package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  // Big-endian lanes: the lowest byte address holds the most significant lane.
  localparam logic [4:0] BE_BYTE0_LSB = 5'd24;
  localparam logic [4:0] BE_BYTE1_LSB = 5'd16;
  localparam logic [4:0] BE_BYTE2_LSB = 5'd8;
  localparam logic [4:0] BE_BYTE3_LSB = 5'd0;
  localparam logic [4:0] BE_HALF0_LSB = 5'd16;
  localparam logic [4:0] BE_HALF1_LSB = 5'd0;

  function automatic logic [4:0] be_byte_lsb(input logic [1:0] off);
    case (off)
      2'd0:    return BE_BYTE0_LSB;
      2'd1:    return BE_BYTE1_LSB;
      2'd2:    return BE_BYTE2_LSB;
      default: return BE_BYTE3_LSB;
    endcase
  endfunction

  // Halfword lane is selected by off[1] only; off[0] is rejected as misaligned.
  function automatic logic [4:0] be_half_lsb(input logic [1:0] off);
    return off[1] ? BE_HALF1_LSB : BE_HALF0_LSB;
  endfunction

  function automatic logic is_misaligned(input size_e size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'd0;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - combinational lane extract/extend and store merge
//
// Purpose: pick the addressed byte/halfword out of a RAM word and extend it to
// 32 bits, and build the read-modify-write word with only that lane replaced.
// Ports:
//   word_i      RAM word read back
//   offset_i    byte offset within the word (addr[1:0])
//   size_i      access size
//   unsigned_i  1 = zero-extend, 0 = sign-extend
//   wdata_i     right-justified store data
//   load_o      extended load value
//   merged_o    word to write back for a store

module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  size_e       size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);

  logic [4:0]  lsb_b;
  logic [4:0]  lsb_h;
  logic [31:0] shr_b;
  logic [31:0] shr_h;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    lsb_b  = be_byte_lsb(offset_i);
    lsb_h  = be_half_lsb(offset_i);
    shr_b  = word_i >> lsb_b;
    shr_h  = word_i >> lsb_h;
    byte_v = shr_b[7:0];
    half_v = shr_h[15:0];
    load_o   = word_i;
    merged_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        load_o   = unsigned_i ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
        merged_o = (word_i & ~(32'h0000_00ff << lsb_b)) | ({24'b0, wdata_i[7:0]} << lsb_b);
      end
      SZ_HALF: begin
        load_o   = unsigned_i ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
        merged_o = (word_i & ~(32'h0000_ffff << lsb_h)) | ({16'b0, wdata_i[15:0]} << lsb_h);
      end
      default: begin
        load_o   = word_i;
        merged_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/halfword/word load-store unit over a synchronous word RAM
//
// Purpose: accepts one request at a time, performs loads, word stores and
// read-modify-write sub-word stores against a word RAM with one-cycle read
// latency, and returns a single-cycle response.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake
//   req_we, req_size, req_unsigned  store flag, access size, zero-extend flag
//   req_addr, req_wdata             byte address, right-justified store data
//   resp_valid, resp_err, resp_rdata  completion pulse, reject flag, load data
//   ram_we, ram_addr, ram_din, ram_dout  word RAM port

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  state_e state_q, state_d;

  logic              we_q, we_d;
  size_e             size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  // Load result or merged store word, captured in WAIT.
  logic [31:0]       data_q, data_d;

  logic [31:0] load_val;
  logic [31:0] merged_val;
  logic        hs;
  logic        misaligned;

  lsu_lane_align u_align (
    .word_i     (ram_dout),
    .offset_i   (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .load_o     (load_val),
    .merged_o   (merged_val)
  );

  assign hs         = req_valid && (state_q == ST_IDLE);
  assign misaligned = is_misaligned(size_e'(req_size), req_addr[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          if (misaligned)                                state_d = ST_RESP;
          else if (req_we && size_e'(req_size) == SZ_WORD) state_d = ST_WR;
          else                                           state_d = ST_RD;
        end
      end
      ST_RD:   state_d = ST_WAIT;
      ST_WAIT: state_d = we_q ? ST_WR : ST_RESP;
      ST_WR:   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch and datapath capture
  always_comb begin
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    data_d  = data_q;
    if (hs) begin
      we_d    = req_we;
      size_d  = size_e'(req_size);
      uns_d   = req_unsigned;
      addr_d  = req_addr;
      wdata_d = req_wdata;
      err_d   = misaligned;
      data_d  = '0;
    end else if (state_q == ST_WAIT) begin
      data_d = we_q ? merged_val : load_val;
    end
  end

  // Outputs
  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    resp_valid = (state_q == ST_RESP);
    resp_err   = (state_q == ST_RESP) && err_q;
    resp_rdata = '0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_din    = '0;
    if (state_q == ST_RESP && !we_q && !err_q) resp_rdata = data_q;
    if (state_q == ST_RD) ram_addr = addr_q[ADDR_W+1:2];
    if (state_q == ST_WR) begin
      // Gated by rst_n so a reset mid-write cannot leak a RAM write.
      ram_we   = rst_n;
      ram_addr = addr_q[ADDR_W+1:2];
      ram_din  = (size_q == SZ_WORD) ? wdata_q : data_q;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit

module tb_load_store_unit;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_unsigned = 1'b0;
  logic [ADDR_W+1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       resp_rdata;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout;

  logic [31:0] mem [1024];

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .resp_rdata   (resp_rdata),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_dout     (ram_dout)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wes;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [11:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rd, input logic err, input int lat, input int wes);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = rd; v.exp_err = err; v.exp_lat = lat; v.exp_wes = wes;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic run_req(input vec_t v, output logic [31:0] rd, output logic er,
                         output int lat, output int wes, output logic stray);
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    rd = 32'hdead_beef; er = 1'bx; lat = 99; wes = 0; stray = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (ram_we) wes++;
      if (resp_valid) begin
        rd = resp_rdata; er = resp_err; lat = c;
        break;
      end else if (resp_rdata != 32'h0) begin
        stray = 1'b1;
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          wes;
    logic        stray;
    logic [11:0] b2b_addr [3];
    logic [31:0] b2b_data [3];
    int          idx;
    int          resp_cnt;
    int          ready_low;
    int          resp_seen;
    logic        hs_now;

    vecs[0]  = mk(1, 2'b10, 0, 12'h010, 32'h1234_5678, 32'h0, 0, 2, 1);
    vecs[1]  = mk(0, 2'b10, 0, 12'h010, 32'h0, 32'h1234_5678, 0, 3, 0);
    vecs[2]  = mk(1, 2'b10, 0, 12'h020, 32'h80FF_7F01, 32'h0, 0, 2, 1);
    vecs[3]  = mk(0, 2'b00, 0, 12'h021, 32'h0, 32'hFFFF_FFFF, 0, 3, 0);
    vecs[4]  = mk(0, 2'b00, 1, 12'h021, 32'h0, 32'h0000_00FF, 0, 3, 0);
    vecs[5]  = mk(0, 2'b01, 0, 12'h020, 32'h0, 32'hFFFF_80FF, 0, 3, 0);
    vecs[6]  = mk(0, 2'b01, 1, 12'h022, 32'h0, 32'h0000_7F01, 0, 3, 0);
    vecs[7]  = mk(1, 2'b10, 0, 12'h030, 32'hAABB_CCDD, 32'h0, 0, 2, 1);
    vecs[8]  = mk(1, 2'b00, 0, 12'h032, 32'hFFFF_FF11, 32'h0, 0, 4, 1);
    vecs[9]  = mk(0, 2'b10, 0, 12'h030, 32'h0, 32'hAABB_11DD, 0, 3, 0);
    vecs[10] = mk(1, 2'b01, 0, 12'h030, 32'hFFFF_2233, 32'h0, 0, 4, 1);
    vecs[11] = mk(0, 2'b10, 0, 12'h030, 32'h0, 32'h2233_11DD, 0, 3, 0);
    vecs[12] = mk(0, 2'b01, 0, 12'h005, 32'h0, 32'h0, 1, 1, 0);
    vecs[13] = mk(1, 2'b10, 0, 12'h006, 32'h1111_1111, 32'h0, 1, 1, 0);
    vecs[14] = mk(0, 2'b11, 0, 12'h040, 32'h0, 32'h0, 1, 1, 0);
    vecs[15] = mk(1, 2'b10, 0, 12'hFFC, 32'hCAFE_BABE, 32'h0, 0, 2, 1);
    vecs[16] = mk(0, 2'b00, 1, 12'hFFF, 32'h0, 32'h0000_00BE, 0, 3, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", {31'b0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check("rst_resp_err", {31'b0, resp_err}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_ram_we", {31'b0, ram_we}, 32'h0);
    check("rst_ram_addr", {22'b0, ram_addr}, 32'h0);
    check("rst_ram_din", ram_din, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      run_req(vecs[i], rd, er, lat, wes, stray);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_ram_we_cycles", i), wes, vecs[i].exp_wes);
      check($sformatf("v%0d_rdata_zero_outside_resp", i), {31'b0, stray}, 32'h0);
    end
    check("top_word_mem", mem[1023], 32'hCAFE_BABE);
    check("rmw_word_mem", mem[12], 32'h2233_11DD);

    // Reset during the WR cycle of a byte store
    run_req(mk(1, 2'b10, 0, 12'h050, 32'h5566_7788, 32'h0, 0, 2, 1), rd, er, lat, wes, stray);
    check("pre_rst_store_latency", lat, 2);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 12'h051; req_wdata = 32'h0000_0099;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("wr_reached", {31'b0, ram_we}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_in_wr_ram_we", {31'b0, ram_we}, 32'h0);
    check("rst_in_wr_req_ready", {31'b0, req_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    resp_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) resp_seen++;
    end
    check("rst_in_wr_no_resp", resp_seen, 0);
    check("rst_in_wr_mem_unchanged", mem[20], 32'h5566_7788);

    // Back-to-back loads with req_valid held high
    b2b_addr[0] = 12'h060; b2b_addr[1] = 12'h064; b2b_addr[2] = 12'h068;
    b2b_data[0] = 32'h0101_0101; b2b_data[1] = 32'h0202_0202; b2b_data[2] = 32'h0303_0303;
    for (int i = 0; i < 3; i++) begin
      run_req(mk(1, 2'b10, 0, b2b_addr[i], b2b_data[i], 32'h0, 0, 2, 1), rd, er, lat, wes, stray);
    end
    @(negedge clk);
    idx = 0; resp_cnt = 0; ready_low = 0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = b2b_addr[0];
    for (int cyc = 0; cyc < 40 && resp_cnt < 3; cyc++) begin
      if (cyc != 0) @(negedge clk);
      if (resp_valid) begin
        if (resp_cnt < 3) check($sformatf("b2b_rdata%0d", resp_cnt), resp_rdata, b2b_data[resp_cnt]);
        resp_cnt++;
      end
      if (!req_ready) ready_low++;
      hs_now = req_ready && req_valid;
      @(posedge clk);
      #1;
      if (hs_now) begin
        idx++;
        if (idx < 3) req_addr = b2b_addr[idx];
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    check("b2b_resp_count", resp_cnt, 3);
    check("b2b_accepted", idx, 3);
    check("b2b_ready_low_cycles", ready_low, 9);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
